// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored {note, duration} table as one-hot note codes for the tone generator
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin playback from entry 0 when idle
//   stop      in   abort playback (wins over start)
//   loop      in   sampled at end of song: 1 = restart at entry 0
//   note      out  one-hot note code, 8'h00 = silence
//   busy      out  high whenever not idle
//   done      out  one-cycle pulse at end of song
//   step_idx  out  index of the table entry currently loaded
//
// Durations are 9 bits wide because the last default entry lasts 500 ticks.
module note_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_TICKS = 20,
  parameter int SONG_LEN  = 16,
  localparam int IW       = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [7:0]    note,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] step_idx
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  // idx must be able to reach SONG_LEN, which acts as an end marker
  localparam int XW       = $clog2(SONG_LEN + 1);
  localparam int DW       = 9;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FINISH} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [7:0]      note_q, note_d;
  logic [IW-1:0]   step_q, step_d;
  logic            busy_q, done_q;
  logic [7+DW:0]   cur;
  logic            wrap;

  function automatic logic [7+DW:0] entry(input logic [XW-1:0] i);
    entry = '0;
    if (i < XW'(7))
      entry = {8'h01 << i, DW'(250)};
    else if (i == XW'(7))
      entry = {8'h80, DW'(500)};
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    step_d  = step_q;
    cur     = entry(idx_q);
    wrap    = presc_q == PW'(TICK_DIV - 1);
    case (state_q)
      IDLE: begin
        note_d = 8'h00;
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (cur[DW-1:0] == '0 || idx_q == XW'(SONG_LEN)) begin
          state_d = FINISH;
        end else begin
          state_d = PLAY;
          note_d  = cur[DW+7:DW];
          cnt_d   = cur[DW-1:0];
          presc_d = '0;
          step_d  = idx_q[IW-1:0];
        end
      end
      PLAY, GAP: begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        cnt_d   = wrap ? cnt_q - DW'(1) : cnt_q;
        // the tick that empties the counter ends this phase
        if (wrap && cnt_q == DW'(1)) begin
          note_d = 8'h00;
          if (state_q == PLAY && GAP_TICKS > 0) begin
            state_d = GAP;
            cnt_d   = DW'(GAP_TICKS);
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + XW'(1);
          end
        end
      end
      FINISH: begin
        note_d  = 8'h00;
        idx_d   = '0;
        state_d = loop ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      note_d  = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      step_q  <= step_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == FINISH;
    end

  assign note     = note_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench with a timeline model of the song for note_sequencer
module tb_note_sequencer;
  localparam int D = 10;
  localparam int G = 2;

  logic       clk = 0;
  logic       rst_n, start, stop, loop;
  logic [7:0] note;
  logic       busy, done;
  logic [3:0] step_idx;
  int         errors = 0;
  int         checks = 0;

  note_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(G), .SONG_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .note(note), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] t_note(input int i);
    return i < 8 ? 8'(1 << i) : 8'h00;
  endfunction

  function automatic int t_dur(input int i);
    return i < 7 ? 250 : (i == 7 ? 500 : 0);
  endfunction

  // Song timeline measured in cycles from the first LOAD of entry 0:
  // each entry is 1 load cycle, dur*D note cycles, G*D silent cycles;
  // the end marker costs one load cycle followed by the finish cycle.
  function automatic void seg(input int k, output logic [7:0] n, output logic fin, output int s);
    int base = 0;
    n = 8'h00; fin = 1'b0; s = -1;
    for (int i = 0; i <= 16; i++) begin
      if (t_dur(i) == 0) begin
        fin = (k == base + 1);
        return;
      end
      if (k < base + 1 + t_dur(i) * D + G * D) begin
        n = (k > base && k <= base + t_dur(i) * D) ? t_note(i) : 8'h00;
        s = k > base ? i : -1;
        return;
      end
      base += 1 + t_dur(i) * D + G * D;
    end
  endfunction

  bit         m_run = 0, nr;
  int         m_off = 0, no, m_step = 0, ns, sa, sn, es;
  logic [7:0] na, nn, en;
  logic       fa, fn, ed;

  always_comb begin
    nr = m_run;
    no = m_off;
    seg(m_off, na, fa, sa);
    if (!m_run) begin
      if (start && !stop) begin
        nr = 1'b1;
        no = 0;
      end
    end else if (stop) nr = 1'b0;
    else if (fa) begin
      nr = loop;
      no = 0;
    end else no = m_off + 1;
    seg(no, nn, fn, sn);
    ns = (nr && sn >= 0) ? sn : m_step;
  end

  always_comb seg(m_off, en, ed, es);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_off  <= 0;
      m_step <= 0;
    end else begin
      m_run  <= nr;
      m_off  <= no;
      m_step <= ns;
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_note", note, m_run ? en : 8'h00);
    chk("model_busy", busy, m_run);
    chk("model_done", done, m_run && ed);
    chk("model_step", step_idx, m_step);
  end

  task automatic run_len(input logic [7:0] v, input int lim, output int n);
    n = 0;
    while (note == v && n < lim) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_note(input string nm, input logic [7:0] v, input int lim);
    int n = 0;
    while (note != v && n < lim) begin
      n++;
      @(negedge clk);
    end
    chk(nm, note, v);
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int n, dn;
    rst_n = 0; start = 0; stop = 0; loop = 0;
    repeat (3) @(negedge clk);
    chk("rst_note", note, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    rst_n = 1;
    @(negedge clk);
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_load_note", note, 0);
    @(negedge clk);
    chk("t1_first_note", note, 8'h01);
    run_len(8'h01, 3000, n);
    chk("t1_note01_len", n, 2500);
    run_len(8'h00, 100, n);
    chk("t1_gap_len", n, 21);
    chk("t1_second_note", note, 8'h02);
    wait_note("t2_reach_80", 8'h80, 20000);
    run_len(8'h80, 6000, n);
    chk("t2_note80_len", n, 5000);
    wait_done(100, n);
    chk("t2_gap_to_done", n, 21);
    chk("t2_done_busy", busy, 1);
    @(negedge clk);
    chk("t2_done_low", done, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_note", note, 0);
    chk("t2_idle_step", step_idx, 7);
    loop = 1;
    pulse_start();
    wait_done(30000, n);
    chk("t3_song_len", n, 22669);
    @(negedge clk);
    chk("t3_reload_note", note, 0);
    @(negedge clk);
    chk("t3_loop_note", note, 8'h01);
    chk("t3_loop_step", step_idx, 0);
    repeat (20) @(negedge clk);
    loop = 0;
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("t3_stop_busy", busy, 0);
    pulse_start();
    wait_note("t4_reach_08", 8'h08, 10000);
    repeat (100) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("t4_stop_note", note, 0);
    chk("t4_stop_busy", busy, 0);
    dn = 0;
    repeat (50) begin
      dn += done;
      @(negedge clk);
    end
    chk("t4_no_done", dn, 0);
    pulse_start();
    @(negedge clk);
    chk("t4_replay_note", note, 8'h01);
    wait_note("t5_reach_04", 8'h04, 6000);
    repeat (300) @(negedge clk);
    pulse_start();
    run_len(8'h04, 3000, n);
    chk("t5_note04_rest", n, 2199);
    chk("t5_step", step_idx, 2);
    stop = 1;
    @(negedge clk);
    stop = 0;
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    chk("t5_ss_busy", busy, 0);
    @(negedge clk);
    chk("t5_ss_note", note, 0);
    pulse_start();
    wait_note("t6_reach_01", 8'h01, 10);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_async_note", note, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_step", step_idx, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    pulse_start();
    @(negedge clk);
    chk("t6_restart_note", note, 8'h01);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
